// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side drain stage with skid buffer, valid/ready output and flush.
// Optional statistics counters are enabled with `define FIFO_RD_STATS_EN.
module fifo_rd_stream #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                           r_clk,
  input  logic                           rst,
  input  logic                           fifo_empty,
  input  logic [DATA_W-1:0]              fifo_rdata,
  output logic                           fifo_rd,
  input  logic                           flush,
  output logic                           m_valid,
  output logic [DATA_W-1:0]              m_data,
  input  logic                           m_ready,
  output logic [$clog2(BUF_DEPTH):0]     occupancy,
  output logic                           busy,
  output logic                           flush_done
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0]               rd_count,
  output logic [CNT_W-1:0]               stall_count
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W:0] DEPTH_L = (OCC_W+1)'(BUF_DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic                   inflight_q;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   flush_done_q, flush_done_d;
  logic [DATA_W-1:0]      buf_q [BUF_DEPTH];
  logic                   wr_en;
  logic                   pop;
  logic [OCC_W:0]         committed;

  assign m_valid    = (state_q == RUN) && (occ_q != '0);
  assign m_data     = buf_q[rd_ptr_q];
  assign occupancy  = occ_q;
  assign flush_done = flush_done_q;
  assign busy       = (state_q == FLUSH) || (occ_q != '0) || inflight_q;
  assign pop        = m_valid && m_ready;
  // Credit counts words already held plus the one still travelling out of the FIFO.
  assign committed  = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    flush_done_d = 1'b0;
    wr_en        = 1'b0;
    fifo_rd      = 1'b0;
    case (state_q)
      RUN: begin
        fifo_rd = !rst && !fifo_empty && (committed < DEPTH_L);
        if (flush) begin
          state_d  = FLUSH;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          occ_d    = '0;
        end else begin
          if (inflight_q) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
          case ({inflight_q, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
          endcase
        end
      end
      FLUSH: begin
        fifo_rd = !rst && !fifo_empty;
        if (fifo_empty && !inflight_q) begin
          state_d      = RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      inflight_q   <= fifo_rd;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      flush_done_q <= flush_done_d;
      if (wr_en) begin
        buf_q[wr_ptr_q] <= fifo_rdata;
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] rd_count_q;
  logic [CNT_W-1:0] stall_count_q;

  assign rd_count    = rd_count_q;
  assign stall_count = stall_count_q;

  // Counters saturate and ignore flush so they reflect consumer-visible traffic.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      rd_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      if (pop && (rd_count_q != '1)) begin
        rd_count_q <= rd_count_q + CNT_W'(1);
      end
      if (m_valid && !m_ready && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed self-checking bench for fifo_rd_stream.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int BD = 4;
  localparam int CW = 16;

  logic          r_clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rd;
  logic          flush;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [2:0]    occupancy;
  logic          busy;
  logic          flush_done;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] rd_count;
  logic [CW-1:0] stall_count;
`endif

  int total = 0;
  int bad   = 0;

  fifo_rd_stream #(.DATA_W(DW), .BUF_DEPTH(BD), .CNT_W(CW)) dut (
    .r_clk      (r_clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .occupancy  (occupancy),
    .busy       (busy),
    .flush_done (flush_done)
`ifdef FIFO_RD_STATS_EN
    ,
    .rd_count   (rd_count),
    .stall_count(stall_count)
`endif
  );

  always #5 r_clk = ~r_clk;

  // Upstream FIFO model: one-cycle read latency, pushes come from the tasks.
  logic [DW-1:0] fmem [0:63];
  int fhead = 0;
  int ftail = 0;
  int rd_pulses = 0;
  int underflows = 0;

  assign fifo_empty = (fhead == ftail);

  always @(posedge r_clk) begin
    if (fifo_rd) begin
      fifo_rdata <= fmem[fhead % 64];
      fhead      <= fhead + 1;
      rd_pulses  <= rd_pulses + 1;
      if (fifo_empty) underflows <= underflows + 1;
    end
  end

  task automatic push(input logic [DW-1:0] v);
    fmem[ftail % 64] = v;
    ftail = ftail + 1;
  endtask

  task automatic test_reset_fill;
    int n;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(i));
    #18;
    total++; if (fifo_rd !== 1'b0) begin bad++; $display("FAIL reset_fifo_rd got=%0b exp=0", fifo_rd); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%0h exp=0", m_data); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    total++; if (busy !== 1'b0 || flush_done !== 1'b0) begin bad++; $display("FAIL reset_busy_fd got=%0b%0b exp=00", busy, flush_done); end
    #5 rst = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge r_clk); n++;
      if (m_valid) break;
    end
    total++; if (n != 2) begin bad++; $display("FAIL fill_latency got=%0d exp=2", n); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        bad++; $display("FAIL fill_word%0d got=%0b/%0h exp=1/%0h", i, m_valid, m_data, i);
      end
      @(negedge r_clk);
    end
    total++; if (m_valid !== 1'b0 || fifo_rd !== 1'b0) begin bad++; $display("FAIL fill_end got=%0b%0b exp=00", m_valid, fifo_rd); end
    total++; if (rd_pulses != 8) begin bad++; $display("FAIL fill_rd_pulses got=%0d exp=8", rd_pulses); end
  endtask

  task automatic test_backpressure;
    int p0, got;
    p0 = rd_pulses;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    repeat (10) begin
      @(negedge r_clk);
      if (m_valid) begin
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL bp_stable got=%0h exp=0", m_data); end
      end
    end
    total++; if (rd_pulses - p0 != 4) begin bad++; $display("FAIL bp_rd_pulses got=%0d exp=4", rd_pulses - p0); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL bp_occ got=%0d exp=4", occupancy); end
    total++; if (m_valid !== 1'b1 || m_data !== 8'h00) begin bad++; $display("FAIL bp_head got=%0b/%0h exp=1/0", m_valid, m_data); end
    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (m_valid) begin
        total++; if (m_data !== 8'(got)) begin bad++; $display("FAIL bp_word%0d got=%0h exp=%0h", got, m_data, got); end
        got++;
      end
      @(negedge r_clk);
    end
    total++; if (got != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", got); end
    repeat (3) @(negedge r_clk);
    total++; if (occupancy !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%0d/%0b exp=0/0", occupancy, busy); end
  endtask

  task automatic test_alternating;
    int got, maxocc;
    got = 0; maxocc = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    for (int c = 0; c < 60 && got < 8; c++) begin
      m_ready = (c % 2 == 0);
      if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
      if (m_valid && m_ready) begin
        total++; if (m_data !== 8'(8'h20 + got)) begin bad++; $display("FAIL alt_word%0d got=%0h exp=%0h", got, m_data, 8'h20 + got); end
        got++;
      end
      @(negedge r_clk);
    end
    m_ready = 1'b1;
    total++; if (got != 8) begin bad++; $display("FAIL alt_count got=%0d exp=8", got); end
    total++; if (maxocc > 4) begin bad++; $display("FAIL alt_maxocc got=%0d exp<=4", maxocc); end
    repeat (3) @(negedge r_clk);
  endtask

  task automatic test_flush;
    int n, pulses;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
    n = 0;
    while (occupancy !== 3'd3 && n < 20) begin @(negedge r_clk); n++; end
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL fl_setup got=%0d exp=3", occupancy); end
    flush = 1'b1;
    @(negedge r_clk);
    flush = 1'b0;
    total++; if (m_valid !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL fl_clear got=%0b/%0d exp=0/0", m_valid, occupancy); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fl_busy got=%0b exp=1", busy); end
    pulses = 0;
    repeat (20) begin
      if (flush_done) pulses++;
      @(negedge r_clk);
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL fl_done_pulses got=%0d exp=1", pulses); end
    total++; if (fifo_empty !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL fl_drained got=%0b%0b%0b exp=100", fifo_empty, busy, m_valid); end
    m_ready = 1'b1;
    push(8'hA5);
    n = 0;
    while (!m_valid && n < 10) begin @(negedge r_clk); n++; end
    total++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin bad++; $display("FAIL fl_new_word got=%0b/%0h exp=1/a5", m_valid, m_data); end
    @(negedge r_clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL fl_new_popped got=%0b exp=0", m_valid); end
  endtask

  task automatic test_async_reset;
    int n, got;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
    n = 0;
    while (occupancy !== 3'd2 && n < 20) begin @(negedge r_clk); n++; end
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL ar_setup got=%0d exp=2", occupancy); end
    #2 rst = 1'b1;
    #1;
    total++; if (fifo_rd !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ar_ctrl got=%0b%0b%0b exp=000", fifo_rd, m_valid, busy); end
    total++; if (m_data !== 8'h00 || occupancy !== 3'd0 || flush_done !== 1'b0) begin bad++; $display("FAIL ar_data got=%0h/%0d/%0b exp=0/0/0", m_data, occupancy, flush_done); end
    @(negedge r_clk);
    rst = 1'b0;
    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (m_valid) begin
        total++; if (m_data !== 8'(8'h43 + got)) begin bad++; $display("FAIL ar_word%0d got=%0h exp=%0h", got, m_data, 8'h43 + got); end
        got++;
      end
      @(negedge r_clk);
    end
    total++; if (got != 3) begin bad++; $display("FAIL ar_count got=%0d exp=3", got); end
    repeat (3) @(negedge r_clk);
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats;
    int n, got;
    rst = 1'b1;
    @(negedge r_clk);
    rst = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
    n = 0;
    while (!m_valid && n < 10) begin @(negedge r_clk); n++; end
    repeat (5) @(negedge r_clk);
    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      if (m_valid) got++;
      @(negedge r_clk);
    end
    total++; if (rd_count !== CW'(8)) begin bad++; $display("FAIL st_rd_count got=%0d exp=8", rd_count); end
    total++; if (stall_count !== CW'(5)) begin bad++; $display("FAIL st_stall_count got=%0d exp=5", stall_count); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset_fill();
    test_backpressure();
    test_alternating();
    test_flush();
    test_async_reset();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    total++; if (underflows != 0) begin bad++; $display("FAIL underflow got=%0d exp=0", underflows); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
